// File: rtl/psum_accum_quant.sv
// psum_accum_quant: multi-pass psum row accumulator with requantised drain.
// Rows accumulate over IC_TILES passes, then stream out as clamped int lanes.
module psum_accum_quant #(
  parameter int PSUM_BW  = 32,
  parameter int NUM_COLS = 32,
  parameter int OUT_BW   = 8,
  parameter int ROW_ADDR = 5
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [5:0]                   NUM_ROWS,
  input  logic [5:0]                   IC_TILES,
  input  logic [15:0]                  QSCALE,
  input  logic [4:0]                   QSHIFT,
  input  logic signed [7:0]            QZERO,
  input  logic                         RELU_EN,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROW_ADDR-1:0]          in_row_addr,
  input  logic [PSUM_BW*NUM_COLS-1:0]  in_psum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROW_ADDR-1:0]          out_row_addr,
  output logic [OUT_BW*NUM_COLS-1:0]   out_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int DEPTH = 1 << ROW_ADDR;
  localparam int RW    = PSUM_BW * NUM_COLS;
  localparam int OW    = OUT_BW * NUM_COLS;
  localparam logic signed [63:0] QMAX = (64'sd1 <<< (OUT_BW - 1)) - 64'sd1;
  localparam logic signed [63:0] QMIN = -(64'sd1 <<< (OUT_BW - 1));

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t            state;
  logic [5:0]        nrows;
  logic [5:0]        ntiles;
  logic [5:0]        row_cnt;
  logic [5:0]        tile_cnt;
  logic [5:0]        rd_ptr;
  logic [15:0]       qscale;
  logic [4:0]        qshift;
  logic signed [7:0] qzero;
  logic              relu_en;

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] sum_row;
  logic [RW-1:0] rd_row;
  logic [OW-1:0] q_row;

  logic beat;
  logic addr_ok;
  logic last_row;
  logic last_tile;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign beat      = in_valid & in_ready;
  assign addr_ok   = 6'(in_row_addr) < nrows;
  assign last_row  = (row_cnt + 6'd1) == nrows;
  assign last_tile = (tile_cnt + 6'd1) == ntiles;
  assign rd_row    = mem[ROW_ADDR'(rd_ptr)];

  function automatic logic [OUT_BW-1:0] quant(
    input logic signed [PSUM_BW-1:0] acc,
    input logic [15:0]               sc,
    input logic [4:0]                sh,
    input logic signed [7:0]         zp,
    input logic                      relu
  );
    logic signed [63:0] p;
    logic signed [63:0] r;
    logic signed [63:0] v;
    p = 64'(acc) * $signed({48'd0, sc});
    r = p;
    if (sh != 5'd0)
      r = (p + (64'sd1 <<< (sh - 5'd1))) >>> sh;
    if (relu && r < 0)
      r = '0;
    v = r + 64'(zp);
    if (v > QMAX)
      v = QMAX;
    else if (v < QMIN)
      v = QMIN;
    return OUT_BW'(v);
  endfunction

  // lane-wise wrapping add of the incoming psum onto the stored row
  always_comb begin
    sum_row = '0;
    for (int l = 0; l < NUM_COLS; l++)
      sum_row[l*PSUM_BW +: PSUM_BW] =
        mem[in_row_addr][l*PSUM_BW +: PSUM_BW] +
        in_psum[l*PSUM_BW +: PSUM_BW];
  end

  // requantise the row currently addressed by the drain pointer
  always_comb begin
    q_row = '0;
    for (int l = 0; l < NUM_COLS; l++)
      q_row[l*OUT_BW +: OUT_BW] =
        quant(rd_row[l*PSUM_BW +: PSUM_BW],
              qscale, qshift, qzero, relu_en);
  end

  // row buffer: first pass overwrites, later passes accumulate
  always_ff @(posedge clk) begin
    if (beat && addr_ok)
      mem[in_row_addr] <= (tile_cnt == 6'd0) ? in_psum : sum_row;
  end

  // job control, pass counting and registered drain output stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      nrows        <= '0;
      ntiles       <= '0;
      row_cnt      <= '0;
      tile_cnt     <= '0;
      rd_ptr       <= '0;
      qscale       <= '0;
      qshift       <= '0;
      qzero        <= '0;
      relu_en      <= 1'b0;
      out_valid    <= 1'b0;
      out_row_addr <= '0;
      out_data     <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nrows    <= NUM_ROWS;
            ntiles   <= IC_TILES;
            qscale   <= QSCALE;
            qshift   <= QSHIFT;
            qzero    <= QZERO;
            relu_en  <= RELU_EN;
            row_cnt  <= '0;
            tile_cnt <= '0;
            rd_ptr   <= '0;
            err      <= 1'b0;
            if (NUM_ROWS == 6'd0 || IC_TILES == 6'd0)
              done <= 1'b1;
            else
              state <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            if (!addr_ok) begin
              err <= 1'b1;
            end else if (last_row) begin
              row_cnt  <= '0;
              tile_cnt <= tile_cnt + 6'd1;
              if (last_tile)
                state <= DRAIN;
            end else begin
              row_cnt <= row_cnt + 6'd1;
            end
          end
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            if (rd_ptr < nrows) begin
              out_valid    <= 1'b1;
              out_data     <= q_row;
              out_row_addr <= ROW_ADDR'(rd_ptr);
              rd_ptr       <= rd_ptr + 6'd1;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_quant.sv
// tb_psum_accum_quant: scenario tasks with random psum rows
// checked against an arithmetic model of accumulation and requant.
module tb_psum_accum_quant;
  localparam int PB = 32;
  localparam int NC = 32;
  localparam int OB = 8;
  localparam int RA = 5;

  logic                clk = 1'b0;
  logic                resetn;
  logic                start;
  logic [5:0]          NUM_ROWS;
  logic [5:0]          IC_TILES;
  logic [15:0]         QSCALE;
  logic [4:0]          QSHIFT;
  logic signed [7:0]   QZERO;
  logic                RELU_EN;
  logic                in_valid;
  logic                in_ready;
  logic [RA-1:0]       in_row_addr;
  logic [PB*NC-1:0]    in_psum;
  logic                out_valid;
  logic                out_ready;
  logic [RA-1:0]       out_row_addr;
  logic [OB*NC-1:0]    out_data;
  logic                busy;
  logic                done;
  logic                err;

  always #5 clk = ~clk;

  psum_accum_quant #(
    .PSUM_BW(PB), .NUM_COLS(NC), .OUT_BW(OB), .ROW_ADDR(RA)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .NUM_ROWS(NUM_ROWS), .IC_TILES(IC_TILES),
    .QSCALE(QSCALE), .QSHIFT(QSHIFT), .QZERO(QZERO),
    .RELU_EN(RELU_EN), .in_valid(in_valid), .in_ready(in_ready),
    .in_row_addr(in_row_addr), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row_addr(out_row_addr), .out_data(out_data),
    .busy(busy), .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  int acc_m [32][NC];
  int nr_c, ic_c, sc_c, sh_c, zp_c;
  bit relu_c;
  int tile_m, row_m;
  bit err_m;

  logic [OB*NC-1:0] got_d [$];
  int               got_a [$];
  bit               done_seen;
  int               first_v;
  int               done_c;
  int               stall_bad;

  function automatic int qm(int acc);
    longint p, r, v;
    p = longint'(acc) * longint'(sc_c);
    if (sh_c > 0) r = (p + (longint'(1) << (sh_c - 1))) >>> sh_c;
    else r = p;
    if (relu_c && r < 0) r = 0;
    v = r + longint'(zp_c);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic logic [OB*NC-1:0] exp_row(int r);
    logic [OB*NC-1:0] e;
    for (int l = 0; l < NC; l++) e[l*OB +: OB] = OB'(qm(acc_m[r][l]));
    return e;
  endfunction

  function automatic logic [PB*NC-1:0] rand_row(bit big);
    logic [PB*NC-1:0] d;
    for (int l = 0; l < NC; l++)
      d[l*PB +: PB] = big ? $urandom : 32'(int'($urandom_range(0, 2000)) - 1000);
    return d;
  endfunction

  task automatic start_job(int nr, int ic, int sc, int sh, int zp, bit relu);
    NUM_ROWS = 6'(nr); IC_TILES = 6'(ic); QSCALE = 16'(sc);
    QSHIFT = 5'(sh); QZERO = 8'(zp); RELU_EN = relu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nr_c = nr; ic_c = ic; sc_c = sc; sh_c = sh; zp_c = zp; relu_c = relu;
    tile_m = 0; row_m = 0; err_m = 0;
  endtask

  task automatic send_beat(int a, logic [PB*NC-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_row_addr = RA'(a); in_psum = d;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL beat_timeout addr=%0d in_ready=%b required=1", a, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (a >= nr_c) begin
      err_m = 1;
    end else begin
      for (int l = 0; l < NC; l++)
        if (tile_m == 0) acc_m[a][l] = int'(d[l*PB +: PB]);
        else acc_m[a][l] = acc_m[a][l] + int'(d[l*PB +: PB]);
      row_m++;
      if (row_m == nr_c) begin row_m = 0; tile_m++; end
    end
  endtask

  task automatic send_pass(bit big);
    int perm [$];
    int j, t;
    for (int i = 0; i < nr_c; i++) perm.push_back(i);
    for (int i = nr_c - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    foreach (perm[i]) send_beat(perm[i], rand_row(big));
  endtask

  task automatic collect(int mode);
    bit pv, pr, r;
    logic [OB*NC-1:0] pd;
    logic [RA-1:0] pa;
    int hold;
    got_d.delete(); got_a.delete();
    done_seen = 0; first_v = -1; done_c = -1; stall_bad = 0;
    pv = 0; pr = 0; hold = 0; pd = '0; pa = '0;
    for (int c = 0; c < 3000; c++) begin
      if (pv && !pr &&
          !(out_valid === 1'b1 && out_data === pd && out_row_addr === pa))
        stall_bad++;
      if (out_valid === 1'b1 && first_v < 0) first_v = c;
      if (done === 1'b1) begin done_seen = 1; done_c = c; break; end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = 1'($urandom_range(0, 1));
      else if (out_valid === 1'b1 && hold < 5) begin r = 1'b0; hold++; end
      else r = 1'b1;
      out_ready = r;
      if (out_valid === 1'b1 && r) begin
        got_d.push_back(out_data);
        got_a.push_back(int'(out_row_addr));
      end
      pv = out_valid; pr = r; pd = out_data; pa = out_row_addr;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    NUM_ROWS = '0; IC_TILES = '0; QSCALE = '0; QSHIFT = '0;
    QZERO = '0; RELU_EN = 1'b0; in_row_addr = '0; in_psum = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {in_ready, out_valid, busy, done, err});
    end
    total++;
    if (out_data !== '0 || out_row_addr !== '0) begin
      bad++;
      $display("FAIL reset_data data=%h addr=%0d required 0", out_data, out_row_addr);
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_basic;
    logic [PB*NC-1:0] r0, r1;
    logic [OB*NC-1:0] e0, e1;
    r0 = {NC{32'sd5}}; r1 = {NC{-32'sd3}};
    e0 = {NC{8'h05}};  e1 = {NC{8'hFD}};
    start_job(2, 1, 1, 0, 0, 0);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_accum busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    send_beat(0, r0);
    send_beat(1, r1);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_drain_entry ov=%b busy=%b rdy=%b required 0 1 0",
               out_valid, busy, in_ready);
    end
    collect(0);
    total++;
    if (first_v !== 1 || done_c !== 3) begin
      bad++;
      $display("FAIL basic_timing first_valid=%0d done=%0d required 1 3", first_v, done_c);
    end
    total++;
    if (got_a.size() != 2 || got_a[0] != 0 || got_a[1] != 1 ||
        got_d[0] !== e0 || got_d[1] !== e1) begin
      bad++;
      $display("FAIL basic_rows n=%0d d0=%h d1=%h required %h %h",
               got_a.size(), got_d[0], got_d[1], e0, e1);
    end
    total++;
    if (!done_seen || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done done=%b ov=%b busy=%b required 1 0 0",
               done_seen, out_valid, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse done=%b required=0", done);
    end
  endtask

  task automatic test_saturate;
    logic [PB*NC-1:0] d;
    start_job(1, 3, 3, 2, 0, 0);
    d = rand_row(0); d[31:0] = 32'sd100;  send_beat(0, d);
    d = rand_row(0); d[31:0] = 32'sd200;  send_beat(0, d);
    d = rand_row(0); d[31:0] = -32'sd50;  send_beat(0, d);
    collect(0);
    total++;
    if (got_d.size() != 1 || got_d[0][7:0] !== 8'd127 || got_d[0] !== exp_row(0)) begin
      bad++;
      $display("FAIL saturate got=%h required=%h (lane0 127)", got_d[0], exp_row(0));
    end
  endtask

  task automatic test_relu;
    logic [PB*NC-1:0] d;
    for (int k = 0; k < 2; k++) begin
      start_job(1, 1, 1, 1, 10, 1'(k));
      d = rand_row(0); d[31:0] = -32'sd7;
      send_beat(0, d);
      collect(0);
      total++;
      if (got_d.size() != 1 || got_d[0][7:0] !== (k == 1 ? 8'd10 : 8'd7) ||
          got_d[0] !== exp_row(0)) begin
        bad++;
        $display("FAIL relu%0d got=%h required=%h", k, got_d[0], exp_row(0));
      end
    end
  endtask

  task automatic test_stall;
    start_job(4, 2, $urandom_range(1, 65535), $urandom_range(0, 15),
              int'($urandom_range(0, 255)) - 128, 0);
    send_pass(0);
    send_pass(0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_in_ready got=%b required=0", in_ready);
    end
    in_valid = 1'b1; in_row_addr = '0; in_psum = rand_row(1);
    collect(2);
    in_valid = 1'b0;
    total++;
    if (stall_bad != 0) begin
      bad++; $display("FAIL stall_hold violations=%0d required=0", stall_bad);
    end
    total++;
    if (got_a.size() != nr_c || !done_seen) begin
      bad++;
      $display("FAIL stall_count rows=%0d done=%b required %0d 1", got_a.size(), done_seen, nr_c);
    end
    foreach (got_d[i]) begin
      total++;
      if (got_a[i] != i || got_d[i] !== exp_row(i)) begin
        bad++;
        $display("FAIL stall_row%0d addr=%0d got=%h required=%h",
                 i, got_a[i], got_d[i], exp_row(i));
      end
    end
  endtask

  task automatic test_bad_addr;
    start_job(4, 1, 1, 0, 0, 0);
    send_beat(6, rand_row(0));
    total++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL badaddr_err err=%b busy=%b required 1 1", err, busy);
    end
    for (int i = 0; i < 3; i++) send_beat(i, rand_row(0));
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL badaddr_uncounted rdy=%b ov=%b required 1 0", in_ready, out_valid);
    end
    send_beat(3, rand_row(0));
    collect(0);
    total++;
    if (got_a.size() != 4 || !done_seen || err !== 1'b1) begin
      bad++;
      $display("FAIL badaddr_drain rows=%0d done=%b err=%b required 4 1 1",
               got_a.size(), done_seen, err);
    end
    foreach (got_d[i]) begin
      total++;
      if (got_a[i] != i || got_d[i] !== exp_row(i)) begin
        bad++;
        $display("FAIL badaddr_row%0d addr=%0d got=%h required=%h",
                 i, got_a[i], got_d[i], exp_row(i));
      end
    end
  endtask

  task automatic test_zero_cfg;
    for (int k = 0; k < 2; k++) begin
      start_job(k == 0 ? 0 : 3, k == 0 ? 3 : 0, 1, 0, 0, 0);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL zero%0d_done done=%b busy=%b err=%b required 1 0 0",
                 k, done, busy, err);
      end
      @(negedge clk);
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL zero%0d_after done=%b ov=%b busy=%b required 0 0 0",
                 k, done, out_valid, busy);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    start_job(3, 2, 1, 0, 0, 0);
    send_pass(1);
    send_beat(0, rand_row(1));
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, busy, done, err} !== 5'b0 ||
        out_data !== '0 || out_row_addr !== '0) begin
      bad++;
      $display("FAIL midreset_outs ctrl=%b data=%h required all 0",
               {in_ready, out_valid, busy, done, err}, out_data);
    end
    resetn = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen++; end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midreset_nodone cycles=%0d required=0", seen);
    end
    start_job(3, 1, 1, 0, 0, 0);
    send_pass(0);
    collect(0);
    total++;
    if (got_a.size() != 3 || !done_seen) begin
      bad++;
      $display("FAIL midreset_rerun rows=%0d done=%b required 3 1", got_a.size(), done_seen);
    end
    foreach (got_d[i]) begin
      total++;
      if (got_a[i] != i || got_d[i] !== exp_row(i)) begin
        bad++;
        $display("FAIL midreset_row%0d addr=%0d got=%h required=%h",
                 i, got_a[i], got_d[i], exp_row(i));
      end
    end
  endtask

  task automatic test_random;
    int nr, ic;
    for (int j = 0; j < 6; j++) begin
      nr = (j == 0) ? 32 : $urandom_range(1, 8);
      ic = (j == 0) ? 2 : $urandom_range(1, 4);
      start_job(nr, ic, $urandom_range(0, 65535), $urandom_range(0, 31),
                int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      for (int p = 0; p < ic; p++) begin
        send_pass(1'(j & 1));
        if (p == 0) begin
          NUM_ROWS = 6'd1; IC_TILES = 6'd1; start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      collect(1);
      total++;
      if (got_a.size() != nr_c || !done_seen || err !== 1'b0) begin
        bad++;
        $display("FAIL rand%0d_job rows=%0d done=%b err=%b required %0d 1 0",
                 j, got_a.size(), done_seen, err, nr_c);
      end
      foreach (got_d[i]) begin
        total++;
        if (got_a[i] != i || got_d[i] !== exp_row(i)) begin
          bad++;
          $display("FAIL rand%0d_row%0d addr=%0d got=%h required=%h",
                   j, i, got_a[i], got_d[i], exp_row(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_relu();
    test_stall();
    test_bad_addr();
    test_zero_cfg();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accum_quant.md
PSUM_ACCUM_QUANT -- requirements
Module: psum_accum_quant

Interface
REQ-001 SHALL take parameter PSUM_BW, default 32, meaning the width of one psum lane.
REQ-002 SHALL take parameter NUM_COLS, default 32, meaning lanes per psum row (PE columns).
REQ-003 SHALL take parameter OUT_BW, default 8, meaning the width of one quantized output lane.
REQ-004 SHALL take parameter ROW_ADDR, default 5, meaning row index width (buffer depth 2^ROW_ADDR = 32 rows).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset is synchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that begins one output-tile job.
REQ-008 SHALL have port NUM_ROWS, input, 6 bits: rows per pass, 1..32.
REQ-009 SHALL have port IC_TILES, input, 6 bits: input-channel passes to accumulate, 1..32.
REQ-010 SHALL have port QSCALE, input, 16 bits, unsigned: requant multiplier.
REQ-011 SHALL have port QSHIFT, input, 5 bits: requant right shift.
REQ-012 SHALL have port QZERO, input, 8 bits, signed: output zero point.
REQ-013 SHALL have port RELU_EN, input, 1 bit: ReLU enable.
REQ-014 SHALL have port in_valid, input, 1 bit: psum row valid.
REQ-015 SHALL have port in_ready, output, 1 bit: psum row accepted.
REQ-016 SHALL have port in_row_addr, input, ROW_ADDR bits: buffer row index of the psum row.
REQ-017 SHALL have port in_psum, input, PSUM_BW*NUM_COLS bits: signed lanes; lane i in bits [PSUM_BW*(i+1)-1 : PSUM_BW*i].
REQ-018 SHALL have port out_valid, input/output direction output, 1 bit; out_ready, input, 1 bit; out_row_addr, output, ROW_ADDR bits; out_data, output, OUT_BW*NUM_COLS bits, with lanes packed as on in_psum.
REQ-019 SHALL have port busy, output, 1 bit; done, output, 1 bit (one-cycle pulse); err, output, 1 bit (sticky).

Function
REQ-020 SHALL implement the states IDLE, ACCUM and DRAIN.
REQ-021 In IDLE, start SHALL latch all config inputs, clear the tile and row counters, clear err, and go to ACCUM; start in ACCUM or DRAIN SHALL be ignored.
REQ-022 A start with NUM_ROWS=0 or IC_TILES=0 SHALL stay in IDLE, pulse done the next cycle, and emit no output.
REQ-023 in_ready SHALL be 1 exactly in ACCUM; busy SHALL be 1 in ACCUM and DRAIN.
REQ-024 On a beat (in_valid & in_ready) with tile_cnt=0, buf[in_row_addr] SHALL be overwritten by in_psum; with tile_cnt>0, each lane SHALL be added to buf with 32-bit two's-complement wrap.
REQ-025 A beat with in_row_addr >= NUM_ROWS SHALL be consumed but discarded, SHALL not be counted, and SHALL set err.
REQ-026 Each counted beat SHALL increment row_cnt; at NUM_ROWS beats, row_cnt SHALL clear and tile_cnt SHALL increment; after the last beat of tile IC_TILES-1 the next state SHALL be DRAIN.
REQ-027 Rows within a pass MAY arrive in any order; a duplicate row in a pass SHALL be accumulated again and counted (the producer's responsibility).
REQ-028 DRAIN SHALL emit rows 0..NUM_ROWS-1 in ascending order, one per out_valid & out_ready handshake, at up to 1 row per cycle.
REQ-029 The first out_valid SHALL assert 1 cycle after DRAIN entry (registered output stage).
REQ-030 While out_valid=1 and out_ready=0, out_data and out_row_addr SHALL hold stable and out_valid SHALL stay 1.
REQ-031 Per lane, p = acc * QSCALE SHALL be computed as a 48-bit signed product.
REQ-032 If QSHIFT>0, r = (p + 2^(QSHIFT-1)) >>> QSHIFT; otherwise r = p.
REQ-033 If RELU_EN and r<0, r SHALL be set to 0.
REQ-034 Then v = r + QZERO SHALL be saturated to [-128, 127].
REQ-035 On the final row handshake, out_valid SHALL drop the next cycle, done SHALL pulse 1 cycle, and the state SHALL return to IDLE.
REQ-036 in_valid outside ACCUM SHALL have no effect.

Reset
REQ-037 While resetn=0 at a clock edge: state=IDLE, counters=0, in_ready=0, out_valid=0, out_data=0, out_row_addr=0, busy=0, done=0, err=0.
REQ-038 Reset mid-job SHALL abort the job with no done pulse; buf contents are not reset and undefined afterwards.

Verification
REQ-039 NUM_ROWS=2, IC_TILES=1, QSCALE=1, QSHIFT=0, QZERO=0; row0 lanes=5, row1 lanes=-3 -> out row0 lanes=5, row1 lanes=-3, then done 1 cycle.
REQ-040 IC_TILES=3, NUM_ROWS=1, lane0 psums 100,200,-50, QSCALE=3, QSHIFT=2 -> acc=250, out lane0=(750+2)>>>2=188, saturated to 127.
REQ-041 Lane acc=-7, QSCALE=1, QSHIFT=1, RELU_EN=0, QZERO=10 -> -3+10=7; the same with RELU_EN=1 -> 10.
REQ-042 out_ready held low 5 cycles in DRAIN -> out_data and out_row_addr stable, out_valid=1 throughout, no row skipped.
REQ-043 NUM_ROWS=4, beat with in_row_addr=6 -> err=1, the beat is not counted, and 4 further valid beats are still needed to finish the pass.
REQ-044 resetn low for 1 cycle mid-ACCUM -> all outputs 0 and no done; a new start then runs correctly from tile 0 (overwrite).
